// File: rtl/stall_countdown_if.sv
// Countdown load request from the hazard detector into stall_countdown.
// Handshake: cd_en is a single-cycle strobe with no ready; the unit always accepts it,
// except that flush or halt in the same cycle drop it. cd_lane/cd_amt are valid while cd_en = 1.
interface stall_countdown_if #(
  parameter int CNT_W = 3
);
  logic             cd_en;
  logic [CNT_W-1:0] cd_amt;
  logic             cd_lane;

  modport master (output cd_en, output cd_amt, output cd_lane);
  modport slave  (input  cd_en, input  cd_amt, input  cd_lane);
endinterface

// File: rtl/stall_countdown.sv
// Per-lane stall down-counters for the dual-issue pipeline; lane state (IDLE/STALL) is cnt != 0.
// Optional STALL_PERF_CNT_EN adds a saturating busy-cycle performance counter on stall_cycles.
module stall_countdown #(
  parameter int CNT_W = 3
) (
  input  logic              clk,
  input  logic              rst_b,
  stall_countdown_if.slave  req,
  input  logic              flush,
  input  logic              halt,
  output logic              stall_1,
  output logic              stall_2,
  output logic [CNT_W-1:0]  cnt_1,
  output logic [CNT_W-1:0]  cnt_2,
  output logic              busy,
  output logic [31:0]       stall_cycles
);

  logic [CNT_W-1:0] dec_1;
  logic [CNT_W-1:0] dec_2;
  logic [CNT_W-1:0] cnt_1_nxt;
  logic [CNT_W-1:0] cnt_2_nxt;
  logic             load;

  always_comb begin
    dec_1     = (cnt_1 != '0) ? cnt_1 - CNT_W'(1) : cnt_1;
    // A lane-1 stall freezes all lane-2 stages, so lane 2 only counts when lane 1 is idle.
    dec_2     = ((cnt_1 == '0) && (cnt_2 != '0)) ? cnt_2 - CNT_W'(1) : cnt_2;
    load      = req.cd_en && (req.cd_amt != '0);
    cnt_1_nxt = dec_1;
    cnt_2_nxt = dec_2;
    if (flush) begin
      cnt_1_nxt = '0;
      cnt_2_nxt = '0;
    end else if (halt) begin
      cnt_1_nxt = cnt_1;
      cnt_2_nxt = cnt_2;
    end else if (load) begin
      // max() so a re-request never shortens a stall already in progress
      if (!req.cd_lane && (req.cd_amt > dec_1)) cnt_1_nxt = req.cd_amt;
      if (req.cd_lane && (req.cd_amt > dec_2))  cnt_2_nxt = req.cd_amt;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      cnt_1 <= '0;
      cnt_2 <= '0;
    end else begin
      cnt_1 <= cnt_1_nxt;
      cnt_2 <= cnt_2_nxt;
    end
  end

  assign stall_1 = (cnt_1 != '0);
  assign stall_2 = (cnt_2 != '0);
  assign busy    = stall_1 | stall_2;

`ifdef STALL_PERF_CNT_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      perf_q <= '0;
    end else if (busy && !halt && (perf_q != 32'hFFFF_FFFF)) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign stall_cycles = perf_q;
`else
  assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_stall_countdown.sv
// Directed-vector bench for stall_countdown: load, re-request, cross-lane hold, flush, halt,
// asynchronous reset and the optional performance counter.
module tb_stall_countdown;

  localparam int CNT_W = 3;

`ifdef STALL_PERF_CNT_EN
  localparam int PERF_ON = 1;
`else
  localparam int PERF_ON = 0;
`endif

  logic              clk;
  logic              rst_b;
  logic              flush;
  logic              halt;
  logic              stall_1;
  logic              stall_2;
  logic [CNT_W-1:0]  cnt_1;
  logic [CNT_W-1:0]  cnt_2;
  logic              busy;
  logic [31:0]       stall_cycles;

  stall_countdown_if #(.CNT_W(CNT_W)) req_if ();

  stall_countdown #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_b        (rst_b),
    .req          (req_if),
    .flush        (flush),
    .halt         (halt),
    .stall_1      (stall_1),
    .stall_2      (stall_2),
    .cnt_1        (cnt_1),
    .cnt_2        (cnt_2),
    .busy         (busy),
    .stall_cycles (stall_cycles)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [2*CNT_W-1:0] exp_q[$];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // driver tasks
  task automatic drive(input logic en, input logic lane, input logic [CNT_W-1:0] amt);
    req_if.cd_en   = en;
    req_if.cd_lane = lane;
    req_if.cd_amt  = amt;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n_hi;
    logic [2*CNT_W-1:0] e;

    rst_b = 1'b0;
    flush = 1'b0;
    halt  = 1'b0;
    drive(1'b0, 1'b0, '0);
    #3;
    check_val("rst_cnt_1", 32'(cnt_1), 0);
    check_val("rst_cnt_2", 32'(cnt_2), 0);
    check_val("rst_busy", 32'(busy), 0);
    check_val("rst_perf", stall_cycles, 0);
    @(negedge clk);
    rst_b = 1'b1;
    tick();

    // basic lane-2 load of 1
    drive(1'b1, 1'b1, 3'd1);
    tick();
    check_val("basic_stall_2", 32'(stall_2), 1);
    check_val("basic_cnt_2", 32'(cnt_2), 1);
    drive(1'b0, 1'b0, '0);
    tick();
    check_val("basic_cnt_2_done", 32'(cnt_2), 0);
    check_val("basic_busy_done", 32'(busy), 0);

    // cd_amt == 0 is a no-op
    drive(1'b1, 1'b0, 3'd0);
    tick();
    check_val("amt0_cnt_1", 32'(cnt_1), 0);
    drive(1'b0, 1'b0, '0);

    // re-request of 2 during a 5-cycle stall must not shorten it
    exp_q = '{6'd5, 6'd4, 6'd3, 6'd2, 6'd1, 6'd0};
    n_hi = 0;
    drive(1'b1, 1'b0, 3'd5);
    for (int k = 0; k < 6; k++) begin
      if (k == 2) drive(1'b1, 1'b0, 3'd2);
      else if (k != 0) drive(1'b0, 1'b0, '0);
      tick();
      e = exp_q.pop_front();
      check_val("rereq_cnt_1", 32'(cnt_1), 32'(e));
      if (stall_1) n_hi++;
    end
    drive(1'b0, 1'b0, '0);
    check_val("rereq_stall_len", 32'(n_hi), 5);

    // larger re-request extends: cnt_1 = 3, load 7 -> 7
    drive(1'b1, 1'b0, 3'd5);
    tick();
    drive(1'b0, 1'b0, '0);
    tick();
    tick();
    check_val("extend_pre", 32'(cnt_1), 3);
    drive(1'b1, 1'b0, 3'd7);
    tick();
    check_val("extend_cnt_1", 32'(cnt_1), 7);
    drive(1'b0, 1'b0, '0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check_val("extend_flush", 32'(cnt_1), 0);

    // cross-lane hold: lane 1 amt 2, then lane 2 amt 3; pairs are {cnt_1, cnt_2}
    drive(1'b1, 1'b0, 3'd2);
    tick();
    drive(1'b1, 1'b1, 3'd3);
    exp_q = '{{3'd1, 3'd3}, {3'd0, 3'd3}, {3'd0, 3'd2}, {3'd0, 3'd1}, {3'd0, 3'd0}};
    for (int k = 0; k < 5; k++) begin
      tick();
      drive(1'b0, 1'b0, '0);
      e = exp_q.pop_front();
      check_val("xlane_cnt", 32'({cnt_1, cnt_2}), 32'(e));
    end

    // flush with cnt_1 = 4, cnt_2 = 2; a simultaneous load is dropped
    drive(1'b1, 1'b0, 3'd5);
    tick();
    drive(1'b1, 1'b1, 3'd2);
    tick();
    check_val("flush_pre", 32'({cnt_1, cnt_2}), 32'({3'd4, 3'd2}));
    drive(1'b1, 1'b0, 3'd7);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 1'b0, '0);
    check_val("flush_cnt_1", 32'(cnt_1), 0);
    check_val("flush_cnt_2", 32'(cnt_2), 0);
    check_val("flush_busy", 32'(busy), 0);

    // halt freezes for 3 cycles; cd_en during halt ignored
    drive(1'b1, 1'b0, 3'd6);
    tick();
    drive(1'b0, 1'b0, '0);
    tick();
    halt = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (k == 1) drive(1'b1, 1'b0, 3'd7);
      else drive(1'b0, 1'b0, '0);
      tick();
      check_val("halt_cnt_1", 32'(cnt_1), 5);
    end
    halt = 1'b0;
    drive(1'b0, 1'b0, '0);
    tick();
    check_val("halt_release", 32'(cnt_1), 4);

    // asynchronous reset between edges while cnt_1 = 6
    drive(1'b1, 1'b0, 3'd7);
    tick();
    drive(1'b0, 1'b0, '0);
    tick();
    check_val("arst_pre", 32'(cnt_1), 6);
    #2;
    rst_b = 1'b0;
    #1;
    check_val("arst_stall_1", 32'(stall_1), 0);
    check_val("arst_cnt_1", 32'(cnt_1), 0);
    check_val("arst_perf", stall_cycles, 0);
    #1;
    rst_b = 1'b1;
    tick();

    // perf counter: 4 busy cycles plus 2 halted busy cycles
    drive(1'b1, 1'b0, 3'd4);
    tick();
    drive(1'b0, 1'b0, '0);
    tick();
    halt = 1'b1;
    tick();
    tick();
    halt = 1'b0;
    tick();
    tick();
    tick();
    check_val("perf_busy_done", 32'(busy), 0);
    tick();
    check_val("perf_cycles", stall_cycles, (PERF_ON != 0) ? 32'd4 : 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
